// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/LSU unified memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_t;

    // One-hot access width codes: byte=0001, half=0010, word=0100, double=1000.
    localparam logic [3:0] WDT_WORD = 4'b0100;

    function automatic int unsigned streak_width(int unsigned max_streak);
        return (max_streak > 0) ? $clog2(max_streak + 1) : 1;
    endfunction

endpackage

// File: rtl/arb_priority_sel.sv
// Combinational winner select between LSU and IF, plus next-streak computation.
module arb_priority_sel #(
    parameter int unsigned MAX_LSU_STREAK = 4,
    parameter int unsigned STREAK_W       = 3
) (
    input  logic                arb_en,
    input  logic                if_req_valid,
    input  logic                if_flush,
    input  logic                lsu_req_valid,
    input  logic [STREAK_W-1:0] streak,
    output logic                grant_if,
    output logic                grant_lsu,
    output logic [STREAK_W-1:0] streak_next
);

    logic if_starved;

    // IF has waited through the maximum number of back-to-back LSU grants.
    assign if_starved = if_req_valid && (streak == STREAK_W'(MAX_LSU_STREAK));

    always_comb begin
        grant_lsu   = arb_en && lsu_req_valid && !if_starved;
        grant_if    = arb_en && !grant_lsu && if_req_valid && !if_flush;
        streak_next = streak;
        if (grant_lsu) begin
            if (!if_req_valid) begin
                streak_next = '0;
            end else if (streak < STREAK_W'(MAX_LSU_STREAK)) begin
                streak_next = streak + 1'b1;
            end
        end else if (grant_if) begin
            streak_next = '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit,
// one transaction in flight, LSU priority with a bounded starvation guard.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W         = 64,
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned INST_W         = 32,
    parameter int unsigned WDT_W          = 4,
    parameter int unsigned MAX_LSU_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_resp_valid,
    output logic [INST_W-1:0] if_resp_inst,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [WDT_W-1:0]  lsu_wdt,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_resp_data,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [WDT_W-1:0]  mem_wdt,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
);

    localparam int unsigned STREAK_W = streak_width(MAX_LSU_STREAK);

    arb_state_t          state_q;
    arb_owner_t          owner_q;
    logic                drop_q;
    logic                lane_q;
    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_next;
    logic                arb_en;
    logic                grant_if;
    logic                grant_lsu;
    logic                flush_hit;

    // Gating with rst_n keeps both readies low while reset is asserted.
    assign arb_en    = rst_n && (state_q == ARB_IDLE);
    assign flush_hit = (owner_q == OWN_IF) && if_flush;

    arb_priority_sel #(
        .MAX_LSU_STREAK (MAX_LSU_STREAK),
        .STREAK_W       (STREAK_W)
    ) u_priority_sel (
        .arb_en        (arb_en),
        .if_req_valid  (if_req_valid),
        .if_flush      (if_flush),
        .lsu_req_valid (lsu_req_valid),
        .streak        (streak_q),
        .grant_if      (grant_if),
        .grant_lsu     (grant_lsu),
        .streak_next   (streak_next)
    );

    assign if_req_ready  = grant_if;
    assign lsu_req_ready = grant_lsu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB_IDLE;
            owner_q       <= OWN_LSU;
            drop_q        <= 1'b0;
            lane_q        <= 1'b0;
            streak_q      <= '0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wdt       <= '0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (grant_lsu || grant_if) begin
                        state_q       <= ARB_REQ;
                        mem_req_valid <= 1'b1;
                        streak_q      <= streak_next;
                        if (grant_lsu) begin
                            owner_q   <= OWN_LSU;
                            mem_addr  <= lsu_addr;
                            mem_wen   <= lsu_wen;
                            mem_wdata <= lsu_wdata;
                            mem_wdt   <= lsu_wdt;
                            lane_q    <= 1'b0;
                        end else begin
                            owner_q   <= OWN_IF;
                            mem_addr  <= if_addr;
                            mem_wen   <= 1'b0;
                            mem_wdata <= '0;
                            mem_wdt   <= WDT_W'(WDT_WORD);
                            lane_q    <= if_addr[2];
                        end
                    end
                end
                ARB_REQ: begin
                    if (flush_hit) begin
                        drop_q <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        state_q       <= ARB_RESP;
                        mem_req_valid <= 1'b0;
                    end
                end
                ARB_RESP: begin
                    if (mem_resp_valid) begin
                        state_q <= ARB_IDLE;
                        drop_q  <= 1'b0;
                    end else if (flush_hit) begin
                        drop_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    // A flushed fetch still completes on the memory side; only its delivery is killed.
    always_comb begin
        if_resp_valid  = 1'b0;
        if_resp_inst   = '0;
        lsu_resp_valid = 1'b0;
        lsu_resp_data  = '0;
        if ((state_q == ARB_RESP) && mem_resp_valid) begin
            if (owner_q == OWN_LSU) begin
                lsu_resp_valid = 1'b1;
                lsu_resp_data  = mem_resp_data;
            end else if (!drop_q && !if_flush) begin
                if_resp_valid = 1'b1;
                if_resp_inst  = lane_q ? mem_resp_data[2*INST_W-1:INST_W]
                                       : mem_resp_data[INST_W-1:0];
            end
        end
    end

    a_resp_only_in_resp: assert property (
        @(posedge clk) disable iff (!rst_n) mem_resp_valid |-> (state_q == ARB_RESP)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model and a behavioural memory.
module tb_mem_port_arbiter;

    localparam int MAX_STREAK = 4;

    logic        clk;
    logic        rst_n = 1'b0;
    logic        if_req_valid, if_req_ready, if_flush, if_resp_valid;
    logic [63:0] if_addr;
    logic [31:0] if_resp_inst;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [63:0] lsu_addr, lsu_wdata, lsu_resp_data;
    logic [3:0]  lsu_wdt;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_resp_data;
    logic [3:0]  mem_wdt;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model controls and captured request.
    int          ready_delay = 0, resp_delay = 0;
    int          mph = 0, wait_c = 0, cap_cnt = 0;
    logic        fixed_en = 1'b0;
    logic [63:0] fixed_data = '0;
    logic [63:0] cap_addr, cap_wdata;
    logic        cap_wen;
    logic [3:0]  cap_wdt;

    mem_port_arbiter #(
        .ADDR_W(64), .DATA_W(64), .INST_W(32), .WDT_W(4), .MAX_LSU_STREAK(MAX_STREAK)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_resp_inst(if_resp_inst),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wdt(lsu_wdt),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wdt(mem_wdt),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(logic [63:0] a);
        return {a[31:0] ^ 32'hA5A5_0F0F, ~a[31:0] + 32'h1234_5678};
    endfunction

    // Memory: accepts after ready_delay cycles, responds resp_delay cycles after that.
    initial begin
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        forever begin
            @(posedge clk); #1;
            mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
            if (!rst_n) begin
                mph = 0;
            end else begin
                if (mph == 0 && mem_req_valid) begin
                    cap_addr = mem_addr; cap_wen = mem_wen; cap_wdata = mem_wdata;
                    cap_wdt = mem_wdt; cap_cnt++; wait_c = ready_delay; mph = 1;
                end
                if (mph == 1) begin
                    if (wait_c == 0) begin mem_req_ready = 1'b1; wait_c = resp_delay; mph = 2; end
                    else wait_c--;
                end else if (mph == 2) begin
                    if (wait_c == 0) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_data  = fixed_en ? fixed_data : mem_word(cap_addr);
                        mph = 0;
                    end else wait_c--;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        if_req_valid = 1'b0; if_addr = '0; if_flush = 1'b0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wdt = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        lsu_req_valid = 1'b1; if_req_valid = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({lsu_req_ready, if_req_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 00", {lsu_req_ready, if_req_ready});
        end
        n_checks++;
        if ({mem_req_valid, mem_wen, mem_wdt, mem_addr, mem_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_reqregs: valid=%b wen=%b wdt=%h addr=%h wdata=%h expected 0",
                               mem_req_valid, mem_wen, mem_wdt, mem_addr, mem_wdata);
        end
        n_checks++;
        if ({lsu_resp_valid, if_resp_valid} !== 2'b00) begin
            n_fail++; $display("FAIL reset_resp: got %b expected 00", {lsu_resp_valid, if_resp_valid});
        end
        tick(); rst_n = 1'b1; idle_inputs();
    endtask

    task automatic test_lsu_load();
        tick();
        fixed_en = 1'b1; fixed_data = 64'h1122_3344_5566_7788; ready_delay = 0; resp_delay = 0;
        lsu_req_valid = 1'b1; lsu_addr = 64'h8000_0010; lsu_wen = 1'b0; lsu_wdt = 4'b1000;
        @(negedge clk);
        n_checks++;
        if ({lsu_req_ready, if_req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL load_grant: got %b expected 10", {lsu_req_ready, if_req_ready});
        end
        tick(); idle_inputs(); @(negedge clk);
        n_checks++;
        if ({mem_req_valid, mem_addr, mem_wen, lsu_resp_valid} !== {1'b1, 64'h8000_0010, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL load_req: valid=%b addr=%h wen=%b rv=%b expected 1 80000010 0 0",
                               mem_req_valid, mem_addr, mem_wen, lsu_resp_valid);
        end
        tick(); @(negedge clk);
        n_checks++;
        if ({lsu_resp_valid, lsu_resp_data, if_resp_valid} !== {1'b1, 64'h1122_3344_5566_7788, 1'b0}) begin
            n_fail++; $display("FAIL load_resp: valid=%b data=%h ifv=%b expected 1 1122334455667788 0",
                               lsu_resp_valid, lsu_resp_data, if_resp_valid);
        end
        tick(); @(negedge clk);
        n_checks++;
        if ({lsu_resp_valid, lsu_resp_data} !== '0) begin
            n_fail++; $display("FAIL load_after: valid=%b data=%h expected 0", lsu_resp_valid, lsu_resp_data);
        end
    endtask

    task automatic test_if_lane();
        logic [63:0] a;
        logic [31:0] e;
        fixed_en = 1'b1; fixed_data = 64'hAAAA_BBBB_CCCC_DDDD;
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? 64'h8000_0004 : 64'h8000_0000;
            e = (i == 0) ? 32'hAAAA_BBBB : 32'hCCCC_DDDD;
            tick(); if_req_valid = 1'b1; if_addr = a; @(negedge clk);
            n_checks++;
            if (if_req_ready !== 1'b1) begin
                n_fail++; $display("FAIL if_grant: ready=%b expected 1", if_req_ready);
            end
            tick(); if_req_valid = 1'b0; @(negedge clk);
            n_checks++;
            if ({mem_wen, mem_wdt, mem_wdata, mem_addr} !== {1'b0, 4'b0100, 64'h0, a}) begin
                n_fail++; $display("FAIL if_req_fields: wen=%b wdt=%b wdata=%h addr=%h expected 0 0100 0 %h",
                                   mem_wen, mem_wdt, mem_wdata, mem_addr, a);
            end
            tick(); @(negedge clk);
            n_checks++;
            if ({if_resp_valid, if_resp_inst, lsu_resp_valid} !== {1'b1, e, 1'b0}) begin
                n_fail++; $display("FAIL if_lane: valid=%b inst=%h lsuv=%b expected 1 %h 0",
                                   if_resp_valid, if_resp_inst, lsu_resp_valid, e);
            end
        end
    endtask

    task automatic test_priority();
        tick();
        lsu_req_valid = 1'b1; lsu_addr = 64'h100; if_req_valid = 1'b1; if_addr = 64'h200;
        @(negedge clk);
        n_checks++;
        if ({lsu_req_ready, if_req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL prio_first: got %b expected 10", {lsu_req_ready, if_req_ready});
        end
        tick(); lsu_req_valid = 1'b0; @(negedge clk);
        n_checks++;
        if ({lsu_req_ready, if_req_ready} !== 2'b00) begin
            n_fail++; $display("FAIL prio_busy: got %b expected 00", {lsu_req_ready, if_req_ready});
        end
        tick(); @(negedge clk);
        n_checks++;
        if ({lsu_resp_valid, if_req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL prio_lsu_resp: got %b expected 10", {lsu_resp_valid, if_req_ready});
        end
        tick(); @(negedge clk);
        n_checks++;
        if (if_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL prio_if_after: ready=%b expected 1", if_req_ready);
        end
        tick(); if_req_valid = 1'b0;
        tick(); @(negedge clk);
        n_checks++;
        if ({if_resp_valid, if_resp_inst} !== {1'b1, 32'hCCCC_DDDD}) begin
            n_fail++; $display("FAIL prio_if_resp: valid=%b inst=%h expected 1 ccccdddd",
                               if_resp_valid, if_resp_inst);
        end
        repeat (2) tick();
    endtask

    task automatic test_streak();
        int n_lsu;
        bit got_if;
        tick();
        if_req_valid = 1'b1; if_addr = 64'h300; lsu_req_valid = 1'b1; lsu_addr = 64'h400;
        for (int round = 0; round < 2; round++) begin
            n_lsu = 0; got_if = 0;
            for (int cyc = 0; cyc < 60 && !got_if; cyc++) begin
                @(negedge clk);
                if (lsu_req_ready) n_lsu++;
                if (if_req_ready) got_if = 1;
                tick();
            end
            n_checks++;
            if (!got_if || n_lsu != MAX_STREAK) begin
                n_fail++; $display("FAIL streak_round%0d: if_granted=%0d lsu_grants=%0d expected 1 %0d",
                                   round, got_if, n_lsu, MAX_STREAK);
            end
        end
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic test_flush();
        bit seen_mem, seen_if;
        logic [63:0] w;
        fixed_en = 1'b0; ready_delay = 3; resp_delay = 0;
        tick(); if_req_valid = 1'b1; if_addr = 64'h500; if_flush = 1'b1; @(negedge clk);
        n_checks++;
        if (if_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle_block: ready=%b expected 0", if_req_ready);
        end
        tick(); if_flush = 1'b0; @(negedge clk);
        n_checks++;
        if (if_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_grant: ready=%b expected 1", if_req_ready);
        end
        tick(); if_req_valid = 1'b0; if_flush = 1'b1;
        tick(); if_flush = 1'b0;
        seen_mem = 0; seen_if = 0;
        for (int cyc = 0; cyc < 20 && !seen_mem; cyc++) begin
            @(negedge clk);
            if (if_resp_valid) seen_if = 1;
            if (mem_resp_valid) seen_mem = 1;
            if (!seen_mem) tick();
        end
        n_checks++;
        if (!seen_mem || seen_if) begin
            n_fail++; $display("FAIL flush_drop: mem_completed=%0d if_resp_seen=%0d expected 1 0",
                               seen_mem, seen_if);
        end
        ready_delay = 0;
        tick(); if_req_valid = 1'b1; if_addr = 64'h504; @(negedge clk);
        n_checks++;
        if (if_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_next_grant: ready=%b expected 1", if_req_ready);
        end
        tick(); if_req_valid = 1'b0;
        tick(); @(negedge clk);
        w = mem_word(64'h504);
        n_checks++;
        if ({if_resp_valid, if_resp_inst} !== {1'b1, w[63:32]}) begin
            n_fail++; $display("FAIL flush_next_resp: valid=%b inst=%h expected 1 %h",
                               if_resp_valid, if_resp_inst, w[63:32]);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        ready_delay = 0; resp_delay = 5;
        tick();
        lsu_req_valid = 1'b1; lsu_addr = 64'h600; lsu_wen = 1'b1;
        lsu_wdata = 64'hDEAD_BEEF; lsu_wdt = 4'b0100;
        @(negedge clk);
        tick(); idle_inputs(); @(negedge clk);
        n_checks++;
        if ({mem_wen, mem_wdata, mem_wdt} !== {1'b1, 64'hDEAD_BEEF, 4'b0100}) begin
            n_fail++; $display("FAIL store_req: wen=%b wdata=%h wdt=%b expected 1 deadbeef 0100",
                               mem_wen, mem_wdata, mem_wdt);
        end
        tick(); @(negedge clk); #1;
        rst_n = 1'b0; lsu_req_valid = 1'b1;
        #1;
        n_checks++;
        if ({mem_req_valid, mem_wen, mem_wdata, mem_addr, mem_wdt, lsu_resp_valid, if_resp_valid,
             lsu_req_ready, if_req_ready} !== '0) begin
            n_fail++; $display("FAIL async_reset: valid=%b wen=%b wdata=%h addr=%h wdt=%b rv=%b%b rdy=%b%b expected 0",
                               mem_req_valid, mem_wen, mem_wdata, mem_addr, mem_wdt, lsu_resp_valid,
                               if_resp_valid, lsu_req_ready, if_req_ready);
        end
        resp_delay = 0;
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1; idle_inputs(); if_req_valid = 1'b1; if_addr = 64'h700;
        @(negedge clk);
        n_checks++;
        if (if_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_grant: ready=%b expected 1", if_req_ready);
        end
        tick(); idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_random();
        int streak = 0, n_done = 0, cap_seen;
        bit busy = 0, own_lsu = 0, dropped = 0, lsu_taken = 0, if_taken = 0;
        bit exp_lr, exp_ir, exp_lv, exp_iv;
        logic [63:0] t_addr = '0, t_wdata = '0, exp_ld, w;
        logic        t_wen = 1'b0;
        logic [3:0]  t_wdt = '0;
        logic [31:0] exp_ii;
        fixed_en = 1'b0;
        tick(); rst_n = 1'b0; idle_inputs();
        repeat (2) tick();
        rst_n = 1'b1;
        cap_seen = cap_cnt;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            ready_delay = $urandom_range(0, 2); resp_delay = $urandom_range(0, 2);
            if (lsu_taken) lsu_req_valid = 1'b0;
            if (if_taken) if_req_valid = 1'b0;
            if (!lsu_req_valid && $urandom_range(0, 2) == 0) begin
                lsu_req_valid = 1'b1; lsu_addr = {32'h0, $urandom};
                lsu_wen = ($urandom_range(0, 1) == 1); lsu_wdata = {$urandom, $urandom};
                lsu_wdt = 4'b0001 << $urandom_range(0, 3);
            end
            if (!if_req_valid && $urandom_range(0, 1) == 0) begin
                if_req_valid = 1'b1; if_addr = {32'h0, $urandom & 32'hFFFF_FFFC};
            end
            if_flush = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            exp_lr = !busy && lsu_req_valid && !(if_req_valid && streak == MAX_STREAK);
            exp_ir = !busy && !exp_lr && if_req_valid && !if_flush;
            n_checks++;
            if ({lsu_req_ready, if_req_ready} !== {exp_lr, exp_ir}) begin
                n_fail++; $display("FAIL rnd_ready cyc %0d: got %b%b expected %b%b",
                                   cyc, lsu_req_ready, if_req_ready, exp_lr, exp_ir);
            end
            exp_lv = 0; exp_iv = 0; exp_ld = '0; exp_ii = '0;
            if (busy && mem_resp_valid) begin
                w = mem_word(t_addr);
                if (own_lsu) begin
                    exp_lv = 1; exp_ld = w;
                end else if (!dropped && !if_flush) begin
                    exp_iv = 1; exp_ii = t_addr[2] ? w[63:32] : w[31:0];
                end
            end
            n_checks++;
            if ({lsu_resp_valid, lsu_resp_data, if_resp_valid, if_resp_inst} !==
                {exp_lv, exp_ld, exp_iv, exp_ii}) begin
                n_fail++; $display("FAIL rnd_resp cyc %0d: lsu %b/%h if %b/%h expected lsu %b/%h if %b/%h",
                                   cyc, lsu_resp_valid, lsu_resp_data, if_resp_valid, if_resp_inst,
                                   exp_lv, exp_ld, exp_iv, exp_ii);
            end
            if (cap_cnt != cap_seen) begin
                cap_seen = cap_cnt;
                n_checks++;
                if ({cap_addr, cap_wen, cap_wdata, cap_wdt} !== {t_addr, t_wen, t_wdata, t_wdt}) begin
                    n_fail++; $display("FAIL rnd_memreq cyc %0d: %h %b %h %b expected %h %b %h %b", cyc,
                                       cap_addr, cap_wen, cap_wdata, cap_wdt, t_addr, t_wen, t_wdata, t_wdt);
                end
            end
            if (busy && mem_resp_valid) begin
                busy = 0; dropped = 0; n_done++;
            end else if (busy && !own_lsu && if_flush) begin
                dropped = 1;
            end
            lsu_taken = exp_lr; if_taken = exp_ir;
            if (exp_lr) begin
                busy = 1; own_lsu = 1; t_addr = lsu_addr; t_wen = lsu_wen;
                t_wdata = lsu_wdata; t_wdt = lsu_wdt;
                streak = !if_req_valid ? 0 : (streak < MAX_STREAK ? streak + 1 : streak);
            end else if (exp_ir) begin
                busy = 1; own_lsu = 0; t_addr = if_addr; t_wen = 1'b0;
                t_wdata = '0; t_wdt = 4'b0100; streak = 0;
            end
        end
        tick(); idle_inputs();
        repeat (8) tick();
        n_checks++;
        if (n_done < 100) begin
            n_fail++; $display("FAIL rnd_activity: completed %0d transactions expected at least 100", n_done);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_lsu_load();
        test_if_lane();
        test_priority();
        test_streak();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
